// File: rtl/load_hazard_scoreboard_pkg.sv
// rtl/load_hazard_scoreboard_pkg.sv - shared constants, entry type and source unpack helper
package load_hazard_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int SRC_MAX  = 8;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } entry_t;

  // Sources are packed LSB-first; callers zero-pad to SRC_MAX entries.
  function automatic logic [REG_W-1:0] src_at(input logic [SRC_MAX*REG_W-1:0] flat, input int i);
    return flat[i*REG_W +: REG_W];
  endfunction

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// rtl/load_hazard_scoreboard_if.sv - pipeline-side bundle of the load hazard scoreboard
interface load_hazard_scoreboard_if #(
  parameter int NSRC  = 2,
  parameter int RW    = 5,
  parameter int DEPTH = 2,
  parameter int CW    = 32
);
  logic [NSRC-1:0]          ex_src_valid;
  logic [NSRC*RW-1:0]       ex_src;
  logic                     ld_issue;
  logic [RW-1:0]            ld_rd;
  logic                     ld_ready;
  logic                     ld_wb;
  logic [RW-1:0]            ld_wb_rd;
  logic                     axi_wait;
  logic                     bubble;
  logic [$clog2(DEPTH):0]   pend_cnt;
  logic                     full;
  logic                     empty;
  logic                     err;
  logic [CW-1:0]            stall_cnt;

  modport master (
    output ex_src_valid, ex_src, ld_issue, ld_rd, ld_wb, ld_wb_rd, axi_wait,
    input  ld_ready, bubble, pend_cnt, full, empty, err, stall_cnt
  );

  modport slave (
    input  ex_src_valid, ex_src, ld_issue, ld_rd, ld_wb, ld_wb_rd, axi_wait,
    output ld_ready, bubble, pend_cnt, full, empty, err, stall_cnt
  );
endinterface

// File: rtl/load_hazard_scoreboard_pend_queue.sv
// rtl/load_hazard_scoreboard_pend_queue.sv - in-order circular queue of outstanding load destinations
module load_hazard_scoreboard_pend_queue
  import load_hazard_scoreboard_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [REG_W-1:0]     push_rd,
  input  logic                 pop,
  output entry_t [DEPTH-1:0]   entries,
  output logic [PW-1:0]        head,
  output logic [CNT_W-1:0]     pend_cnt,
  output logic                 full,
  output logic                 empty
);

  logic [PW-1:0] tail;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  assign full   = (pend_cnt == CNT_W'(DEPTH));
  assign empty  = (pend_cnt == '0);
  assign pop_ok = pop && !empty;

  // Pop invalidates before push writes, so a DEPTH=1 push+pop overwrites the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries  <= '0;
      head     <= '0;
      tail     <= '0;
      pend_cnt <= '0;
    end else begin
      if (pop_ok) begin
        entries[head].valid <= 1'b0;
        head                <= ptr_inc(head);
      end
      if (push) begin
        entries[tail] <= {1'b1, push_rd};
        tail          <= ptr_inc(tail);
      end
      if (push && !pop_ok)
        pend_cnt <= pend_cnt + 1'b1;
      else if (!push && pop_ok)
        pend_cnt <= pend_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// rtl/load_hazard_scoreboard.sv - multi-load RAW hazard scoreboard and bubble generator between EX and MEM
module load_hazard_scoreboard
  import load_hazard_scoreboard_pkg::*;
#(
  parameter int NREG      = NUM_REGS,
  parameter int RW        = REG_W,
  parameter int NSRC      = 2,
  parameter int DEPTH     = 2,
  parameter int BYPASS_WB = 1,
  parameter int CW        = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_hazard_scoreboard_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (RW != REG_W || (1 << RW) < NREG || NSRC > SRC_MAX || NSRC < 1) begin : g_bad_cfg
    $error("load_hazard_scoreboard: unsupported RW/NREG/NSRC combination");
  end

  entry_t [DEPTH-1:0]          entries;
  logic [PW-1:0]               head;
  logic                        push;
  logic                        hazard;
  logic                        wb_bad;
  logic                        err_q;
  logic [CW-1:0]               stall_q;
  logic [SRC_MAX*REG_W-1:0]    src_flat;

  assign bus.ld_ready = !bus.full || bus.ld_wb;
  assign push         = bus.ld_issue && bus.ld_ready;

  load_hazard_scoreboard_pend_queue #(.DEPTH(DEPTH)) u_pend_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rd  (bus.ld_rd),
    .pop      (bus.ld_wb),
    .entries  (entries),
    .head     (head),
    .pend_cnt (bus.pend_cnt),
    .full     (bus.full),
    .empty    (bus.empty)
  );

  // With WB forwarding the returning head load is already satisfied, so it is masked out.
  always_comb begin
    hazard   = 1'b0;
    src_flat = '0;
    src_flat[NSRC*REG_W-1:0] = bus.ex_src;
    for (int i = 0; i < NSRC; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (bus.ex_src_valid[i] && (src_at(src_flat, i) != '0) &&
            entries[e].valid && (entries[e].rd == src_at(src_flat, i)) &&
            !((BYPASS_WB != 0) && bus.ld_wb && (PW'(e) == head)))
          hazard = 1'b1;
      end
    end
  end

  assign bus.bubble = bus.axi_wait || hazard || (bus.ld_issue && !bus.ld_ready);
  assign wb_bad     = bus.ld_wb && (bus.empty || (bus.ld_wb_rd != entries[head].rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      if (wb_bad)
        err_q <= 1'b1;
      if (bus.bubble && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.err       = err_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// tb/tb_load_hazard_scoreboard.sv - directed self-checking bench for load_hazard_scoreboard
module tb_load_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  load_hazard_scoreboard_if #(.NSRC(2), .RW(5), .DEPTH(2), .CW(32)) if0 ();
  load_hazard_scoreboard_if #(.NSRC(2), .RW(5), .DEPTH(2), .CW(3))  if1 ();

  load_hazard_scoreboard #(.NREG(32), .RW(5), .NSRC(2), .DEPTH(2), .BYPASS_WB(1), .CW(32)) u0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );

  load_hazard_scoreboard #(.NREG(32), .RW(5), .NSRC(2), .DEPTH(2), .BYPASS_WB(0), .CW(3)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  task automatic clear_inputs();
    if0.ex_src_valid = '0; if0.ex_src = '0; if0.ld_issue = 0; if0.ld_rd = '0;
    if0.ld_wb = 0; if0.ld_wb_rd = '0; if0.axi_wait = 0;
    if1.ex_src_valid = '0; if1.ex_src = '0; if1.ld_issue = 0; if1.ld_rd = '0;
    if1.ld_wb = 0; if1.ld_wb_rd = '0; if1.axi_wait = 0;
  endtask

  // Leaves the bench just after a negedge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL reset_bubble: got %0b want 0", if0.bubble); else n_pass++;
    n_total++; if (if0.empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", if0.empty); else n_pass++;
    n_total++; if (if0.full !== 1'b0) $display("FAIL reset_full: got %0b want 0", if0.full); else n_pass++;
    n_total++; if (if0.ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %0b want 1", if0.ld_ready); else n_pass++;
    n_total++; if (if0.pend_cnt !== 2'd0) $display("FAIL reset_pend_cnt: got %0d want 0", if0.pend_cnt); else n_pass++;
    n_total++; if (if0.stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d want 0", if0.stall_cnt); else n_pass++;
    n_total++; if (if0.err !== 1'b0) $display("FAIL reset_err: got %0b want 0", if0.err); else n_pass++;
    if0.axi_wait = 1; #1;
    n_total++; if (if0.bubble !== 1'b1) $display("FAIL reset_bubble_axi: got %0b want 1", if0.bubble); else n_pass++;
    if0.axi_wait = 0;
  endtask

  task automatic test_raw_bypass();
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd5; #1;
    n_total++; if (if0.ld_ready !== 1'b1) $display("FAIL raw_issue_ready: got %0b want 1", if0.ld_ready); else n_pass++;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL raw_same_cycle_bubble: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    if0.ld_issue = 0; if0.ex_src_valid = 2'b01; if0.ex_src = {5'd0, 5'd5}; #1;
    n_total++; if (if0.bubble !== 1'b1) $display("FAIL raw_hazard_bubble: got %0b want 1", if0.bubble); else n_pass++;
    n_total++; if (if0.pend_cnt !== 2'd1) $display("FAIL raw_pend_cnt: got %0d want 1", if0.pend_cnt); else n_pass++;
    @(negedge clk);
    if0.ld_wb = 1; if0.ld_wb_rd = 5'd5; #1;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL raw_bypass_bubble: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.empty !== 1'b1) $display("FAIL raw_empty_after_wb: got %0b want 1", if0.empty); else n_pass++;
    n_total++; if (if0.err !== 1'b0) $display("FAIL raw_err: got %0b want 0", if0.err); else n_pass++;
    n_total++; if (if0.stall_cnt !== 32'd1) $display("FAIL raw_stall_cnt: got %0d want 1", if0.stall_cnt); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd3;
    @(negedge clk);
    if0.ld_rd = 5'd4;
    @(negedge clk);
    if0.ld_rd = 5'd6; #1;
    n_total++; if (if0.full !== 1'b1) $display("FAIL full_flag: got %0b want 1", if0.full); else n_pass++;
    n_total++; if (if0.ld_ready !== 1'b0) $display("FAIL full_ld_ready: got %0b want 0", if0.ld_ready); else n_pass++;
    n_total++; if (if0.bubble !== 1'b1) $display("FAIL full_struct_bubble: got %0b want 1", if0.bubble); else n_pass++;
    @(negedge clk);
    if0.ld_wb = 1; if0.ld_wb_rd = 5'd3; #1;
    n_total++; if (if0.ld_ready !== 1'b1) $display("FAIL full_pushpop_ready: got %0b want 1", if0.ld_ready); else n_pass++;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL full_pushpop_bubble: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    clear_inputs(); if0.ex_src = {5'd6, 5'd4}; #1;
    n_total++; if (if0.pend_cnt !== 2'd2) $display("FAIL full_pend_cnt_kept: got %0d want 2", if0.pend_cnt); else n_pass++;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL full_invalid_src_ignored: got %0b want 0", if0.bubble); else n_pass++;
    if0.ex_src_valid = 2'b01; #1;
    n_total++; if (if0.bubble !== 1'b1) $display("FAIL full_holds_4: got %0b want 1", if0.bubble); else n_pass++;
    if0.ex_src_valid = 2'b10; #1;
    n_total++; if (if0.bubble !== 1'b1) $display("FAIL full_holds_6_src1: got %0b want 1", if0.bubble); else n_pass++;
    if0.ex_src_valid = 2'b01; if0.ex_src = {5'd0, 5'd3}; #1;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL full_3_popped: got %0b want 0", if0.bubble); else n_pass++;
    clear_inputs(); if0.ld_wb = 1; if0.ld_wb_rd = 5'd4;
    @(negedge clk);
    if0.ld_wb_rd = 5'd6;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b0) $display("FAIL full_order_err: got %0b want 0", if0.err); else n_pass++;
    n_total++; if (if0.empty !== 1'b1) $display("FAIL full_drained_empty: got %0b want 1", if0.empty); else n_pass++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd0;
    @(negedge clk);
    if0.ld_issue = 0; if0.ex_src_valid = 2'b11; if0.ex_src = {5'd0, 5'd0}; #1;
    n_total++; if (if0.pend_cnt !== 2'd1) $display("FAIL zero_queued: got %0d want 1", if0.pend_cnt); else n_pass++;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL zero_no_hazard: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    clear_inputs(); if0.ld_wb = 1; if0.ld_wb_rd = 5'd0;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b0) $display("FAIL zero_wb_err: got %0b want 0", if0.err); else n_pass++;
  endtask

  task automatic test_no_bypass();
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd7;
    if1.ld_issue = 1; if1.ld_rd = 5'd7;
    @(negedge clk);
    if0.ld_issue = 0; if0.ld_wb = 1; if0.ld_wb_rd = 5'd7; if0.ex_src_valid = 2'b01; if0.ex_src = {5'd0, 5'd7};
    if1.ld_issue = 0; if1.ld_wb = 1; if1.ld_wb_rd = 5'd7; if1.ex_src_valid = 2'b01; if1.ex_src = {5'd0, 5'd7};
    #1;
    n_total++; if (if1.bubble !== 1'b1) $display("FAIL nobypass_bubble: got %0b want 1", if1.bubble); else n_pass++;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL bypass_bubble: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if1.empty !== 1'b1) $display("FAIL nobypass_empty: got %0b want 1", if1.empty); else n_pass++;
    n_total++; if (if1.stall_cnt !== 3'd1) $display("FAIL nobypass_stall: got %0d want 1", if1.stall_cnt); else n_pass++;
  endtask

  task automatic test_err();
    do_reset();
    if0.ld_wb = 1; if0.ld_wb_rd = 5'd9; #1;
    n_total++; if (if0.err !== 1'b0) $display("FAIL err_not_early: got %0b want 0", if0.err); else n_pass++;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b1) $display("FAIL err_empty_wb: got %0b want 1", if0.err); else n_pass++;
    n_total++; if (if0.pend_cnt !== 2'd0) $display("FAIL err_pend_cnt: got %0d want 0", if0.pend_cnt); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (if0.err !== 1'b1) $display("FAIL err_sticky: got %0b want 1", if0.err); else n_pass++;
    do_reset(); #1;
    n_total++; if (if0.err !== 1'b0) $display("FAIL err_cleared: got %0b want 0", if0.err); else n_pass++;
    if0.ld_issue = 1; if0.ld_rd = 5'd8;
    @(negedge clk);
    if0.ld_issue = 0; if0.ld_wb = 1; if0.ld_wb_rd = 5'd9;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b1) $display("FAIL err_rd_mismatch: got %0b want 1", if0.err); else n_pass++;
    n_total++; if (if0.pend_cnt !== 2'd0) $display("FAIL err_mismatch_popped: got %0d want 0", if0.pend_cnt); else n_pass++;
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd8;
    do_reset(); #1;
    n_total++; if (if0.empty !== 1'b1) $display("FAIL err_midop_discard: got %0b want 1", if0.empty); else n_pass++;
    if0.ld_wb = 1; if0.ld_wb_rd = 5'd8;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b1) $display("FAIL err_midop_wb: got %0b want 1", if0.err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    if0.ld_issue = 1; if0.ld_rd = 5'd1;
    @(negedge clk);
    if0.ld_rd = 5'd2; if0.ld_wb = 1; if0.ld_wb_rd = 5'd1;
    @(negedge clk);
    if0.ld_rd = 5'd3; if0.ld_wb_rd = 5'd2; #1;
    n_total++; if (if0.pend_cnt !== 2'd1) $display("FAIL b2b_pend_cnt: got %0d want 1", if0.pend_cnt); else n_pass++;
    @(negedge clk);
    if0.ld_issue = 0; if0.ld_wb_rd = 5'd3; if0.ex_src_valid = 2'b10; if0.ex_src = {5'd3, 5'd0}; #1;
    n_total++; if (if0.bubble !== 1'b0) $display("FAIL b2b_bypass_bubble: got %0b want 0", if0.bubble); else n_pass++;
    @(negedge clk);
    clear_inputs(); #1;
    n_total++; if (if0.err !== 1'b0) $display("FAIL b2b_err: got %0b want 0", if0.err); else n_pass++;
    n_total++; if (if0.empty !== 1'b1) $display("FAIL b2b_empty: got %0b want 1", if0.empty); else n_pass++;
  endtask

  task automatic test_axi_wait();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if0.axi_wait = (i < 5);
      if1.axi_wait = 1;
      #1;
      if (i < 5) begin
        n_total++; if (if0.bubble !== 1'b1) $display("FAIL axi_bubble_%0d: got %0b want 1", i, if0.bubble); else n_pass++;
      end
      if (i == 5) begin
        n_total++; if (if1.stall_cnt !== 3'd5) $display("FAIL sat_mid: got %0d want 5", if1.stall_cnt); else n_pass++;
      end
      @(negedge clk);
    end
    clear_inputs(); #1;
    n_total++; if (if0.stall_cnt !== 32'd5) $display("FAIL axi_stall_cnt: got %0d want 5", if0.stall_cnt); else n_pass++;
    n_total++; if (if1.stall_cnt !== 3'd7) $display("FAIL stall_saturate: got %0d want 7", if1.stall_cnt); else n_pass++;
    n_total++; if (if0.ld_ready !== 1'b1) $display("FAIL axi_ld_ready: got %0b want 1", if0.ld_ready); else n_pass++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_raw_bypass();
    test_full();
    test_zero_reg();
    test_no_bypass();
    test_err();
    test_back_to_back();
    test_axi_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
